hwpe_ctrl_seq_mult_ext: RTL and testbench

Parametrised sequential multiplier for HWPE controller arithmetic, such as address strides and loop-bound products. It consumes RADIX_BITS bits of operand A per cycle and supports signed and unsigned operation per transaction. Operands are latched on start, so callers do not need to hold them stable. Requests use a start/ready handshake and results use a valid/ready handshake, so the block drops into controller FSMs and uloop datapaths without external holding registers.

---
 rtl/hwpe_ctrl_seq_mult_ext_pkg.sv | 12 +
 rtl/hwpe_ctrl_seq_mult_ext_pp.sv | 34 +++
 rtl/hwpe_ctrl_seq_mult_ext.sv | 133 +++++++++++++
 tb/tb_hwpe_ctrl_seq_mult_ext.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_ctrl_seq_mult_ext_pkg.sv
// Shared types and defaults for the HWPE controller sequential multiplier.
package hwpe_ctrl_package;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } hwpe_ctrl_seq_mult_state_t;

    localparam int unsigned RADIX_BITS_DEFAULT = 2;

endpackage

// File: rtl/hwpe_ctrl_seq_mult_ext_pp.sv
// Combinational partial-product term: one radix digit of A times B, shifted into place,
// with the top digit treated as negative-weighted in signed mode.
module hwpe_ctrl_seq_mult_pp
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned AW         = 16,
    parameter int unsigned BW         = 16,
    parameter int unsigned RADIX_BITS = RADIX_BITS_DEFAULT,
    parameter int unsigned CW         = 1
) (
    input  logic [RADIX_BITS-1:0] digit,
    input  logic [BW-1:0]         b,
    input  logic                  signed_mode,
    input  logic                  last,
    input  logic [CW-1:0]         cnt,
    output logic [AW+BW-1:0]      term
);

    localparam int unsigned PW = AW + BW;

    logic [PW-1:0] digit_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] raw;

    // Products are taken modulo 2^PW, so sign-extending the last digit gives the -2^(AW-1) weight.
    always_comb begin
        b_ext     = signed_mode ? {{AW{b[BW-1]}}, b} : {{AW{1'b0}}, b};
        digit_ext = (signed_mode && last) ? {{(PW-RADIX_BITS){digit[RADIX_BITS-1]}}, digit}
                                          : {{(PW-RADIX_BITS){1'b0}}, digit};
        raw       = digit_ext * b_ext;
        term      = raw << (32'(cnt) * RADIX_BITS);
    end

endmodule

// File: rtl/hwpe_ctrl_seq_mult_ext.sv
// Radix-2^RADIX_BITS sequential multiplier with start/ready request and valid/ready result.
// Optional accumulate mode is enabled by defining HWPE_CTRL_SEQ_MULT_ACC_EN.
module hwpe_ctrl_seq_mult_ext
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned AW         = 16,
    parameter int unsigned BW         = 16,
    parameter int unsigned RADIX_BITS = RADIX_BITS_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               start_i,
    output logic               ready_o,
    input  logic               signed_i,
    input  logic [AW-1:0]      a_i,
    input  logic [BW-1:0]      b_i,
`ifdef HWPE_CTRL_SEQ_MULT_ACC_EN
    input  logic               acc_i,
`endif
    output logic               valid_o,
    input  logic               ready_i,
    output logic [AW+BW-1:0]   prod_o
);

    localparam int unsigned N  = AW / RADIX_BITS;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = AW + BW;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    if (AW % RADIX_BITS != 0) begin : g_bad_radix
        $error("AW must be a multiple of RADIX_BITS");
    end

    hwpe_ctrl_seq_mult_state_t state, next_state;

    logic [CW-1:0] cnt;
    logic [AW-1:0] a_q;
    logic [BW-1:0] b_q;
    logic          signed_q;
    logic          acc_q;
    logic [PW-1:0] prod_q;
    logic [PW-1:0] term;
    logic [PW-1:0] base;
    logic          last;

    assign last    = (cnt == LAST_CNT);
    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);
    assign prod_o  = prod_q;

    // The first RUN cycle adds onto zero instead of clearing prod_q at accept,
    // so the previous result stays visible in IDLE.
    assign base = (cnt == '0 && !acc_q) ? '0 : prod_q;

    hwpe_ctrl_seq_mult_pp #(
        .AW         (AW),
        .BW         (BW),
        .RADIX_BITS (RADIX_BITS),
        .CW         (CW)
    ) i_pp (
        .digit       (a_q[RADIX_BITS-1:0]),
        .b           (b_q),
        .signed_mode (signed_q),
        .last        (last),
        .cnt         (cnt),
        .term        (term)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_i) next_state = RUN;
            RUN:     if (last)    next_state = DONE;
            DONE:    if (ready_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (clear_i) next_state = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            prod_q   <= '0;
        end else if (clear_i) begin
            cnt    <= '0;
            prod_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q      <= a_i;
                        b_q      <= b_i;
                        signed_q <= signed_i;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    prod_q <= base + term;
                    a_q    <= a_q >> RADIX_BITS;
                    cnt    <= last ? '0 : cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef HWPE_CTRL_SEQ_MULT_ACC_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= 1'b0;
        end else if (clear_i) begin
            acc_q <= 1'b0;
        end else if (state == IDLE && start_i) begin
            acc_q <= acc_i;
        end
    end
`else
    assign acc_q = 1'b0;
`endif

endmodule

// File: tb/tb_hwpe_ctrl_seq_mult_ext.sv
// Directed self-checking bench for hwpe_ctrl_seq_mult_ext with AW = BW = 8, RADIX_BITS = 2.
module tb_hwpe_ctrl_seq_mult_ext;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        ready;
    logic        sgn = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        valid;
    logic        take = 1'b0;
    logic [15:0] prod;
`ifdef HWPE_CTRL_SEQ_MULT_ACC_EN
    logic        acc_in = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hwpe_ctrl_seq_mult_ext #(.AW(8), .BW(8), .RADIX_BITS(2)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (clear),
        .start_i  (start),
        .ready_o  (ready),
        .signed_i (sgn),
        .a_i      (a),
        .b_i      (b),
`ifdef HWPE_CTRL_SEQ_MULT_ACC_EN
        .acc_i    (acc_in),
`endif
        .valid_o  (valid),
        .ready_i  (take),
        .prod_o   (prod)
    );

    // Accept one request from IDLE and wait (bounded) for valid; operands are scrambled after accept.
    task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic sg,
                         output int lat, output logic ready_seen);
        start = 1'b1; a = op_a; b = op_b; sgn = sg;
        @(posedge clk); #1;
        start = 1'b0; a = 8'h5A; b = 8'hA5; sgn = ~sg;
        lat = 0;
        ready_seen = 1'b0;
        while (!valid && lat < 20) begin
            if (ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        take = 1'b1;
        @(posedge clk); #1;
        take = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", ready); end
        vectors++;
        if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid); end
        vectors++;
        if (prod !== 16'h0000) begin miscompares++; $display("FAIL reset_prod: got %h expected 0000", prod); end
    endtask

    task automatic test_unsigned();
        int lat;
        logic rs;
        do_op(8'd200, 8'd150, 1'b0, lat, rs);
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL unsigned_latency: got %0d expected 4", lat); end
        vectors++;
        if (rs !== 1'b0) begin miscompares++; $display("FAIL unsigned_ready_in_run: got %b expected 0", rs); end
        vectors++;
        if (prod !== 16'h7530) begin miscompares++; $display("FAIL unsigned_200x150: got %h expected 7530", prod); end
        release_result();
        vectors++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            miscompares++; $display("FAIL unsigned_handoff: got ready=%b valid=%b expected ready=1 valid=0", ready, valid);
        end
    endtask

    task automatic test_signed();
        int lat;
        logic rs;
        do_op(8'hFD, 8'h05, 1'b1, lat, rs);
        vectors++;
        if (prod !== 16'hFFF1) begin miscompares++; $display("FAIL signed_m3x5: got %h expected fff1", prod); end
        release_result();
        do_op(8'h80, 8'h80, 1'b1, lat, rs);
        vectors++;
        if (prod !== 16'h4000) begin miscompares++; $display("FAIL signed_80x80: got %h expected 4000", prod); end
        release_result();
    endtask

    task automatic test_extremes();
        int lat;
        logic rs;
        do_op(8'hFF, 8'hFF, 1'b0, lat, rs);
        vectors++;
        if (prod !== 16'hFE01) begin miscompares++; $display("FAIL unsigned_ffxff: got %h expected fe01", prod); end
        release_result();
        do_op(8'hFF, 8'hFF, 1'b1, lat, rs);
        vectors++;
        if (prod !== 16'h0001) begin miscompares++; $display("FAIL signed_ffxff: got %h expected 0001", prod); end
        release_result();
    endtask

    task automatic test_ignore_start_and_stall();
        int lat;
        start = 1'b1; a = 8'd7; b = 8'd9; sgn = 1'b0;
        @(posedge clk); #1;
        a = 8'hFF; b = 8'hFF; sgn = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL ignore_start_latency: got %0d expected 4", lat); end
        vectors++;
        if (prod !== 16'h003F) begin miscompares++; $display("FAIL ignore_start_prod: got %h expected 003f", prod); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (valid !== 1'b1 || prod !== 16'h003F) begin
                miscompares++; $display("FAIL stall_hold_%0d: got valid=%b prod=%h expected valid=1 prod=003f", i, valid, prod);
            end
        end
        take = 1'b1;
        vectors++;
        if (ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready_early: got %b expected 0", ready); end
        @(posedge clk); #1;
        take = 1'b0;
        vectors++;
        if (ready !== 1'b1 || valid !== 1'b0 || prod !== 16'h003F) begin
            miscompares++; $display("FAIL stall_release: got ready=%b valid=%b prod=%h expected 1 0 003f", ready, valid, prod);
        end
    endtask

    task automatic test_clear_and_reset();
        logic seen;
        int lat;
        logic rs;
        start = 1'b1; a = 8'd201; b = 8'd150; sgn = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        vectors++;
        if (ready !== 1'b1 || valid !== 1'b0 || prod !== 16'h0000) begin
            miscompares++; $display("FAIL clear_abort: got ready=%b valid=%b prod=%h expected 1 0 0000", ready, valid, prod);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (valid) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("FAIL clear_no_valid: got %b expected 0", seen); end

        start = 1'b1; a = 8'd201; b = 8'd150; sgn = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (ready !== 1'b1 || valid !== 1'b0 || prod !== 16'h0000) begin
            miscompares++; $display("FAIL reset_abort: got ready=%b valid=%b prod=%h expected 1 0 0000", ready, valid, prod);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (valid) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("FAIL reset_no_valid: got %b expected 0", seen); end
        do_op(8'd3, 8'd5, 1'b0, lat, rs);
        vectors++;
        if (prod !== 16'h000F) begin miscompares++; $display("FAIL after_reset_3x5: got %h expected 000f", prod); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic rs;
        take = 1'b1;
        do_op(8'd12, 8'd12, 1'b0, lat, rs);
        vectors++;
        if (prod !== 16'h0090) begin miscompares++; $display("FAIL b2b_first: got %h expected 0090", prod); end
        @(posedge clk); #1;
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b expected 1", ready); end
        do_op(8'd16, 8'd16, 1'b0, lat, rs);
        vectors++;
        if (prod !== 16'h0100 || lat !== 4) begin
            miscompares++; $display("FAIL b2b_second: got prod=%h lat=%0d expected 0100 4", prod, lat);
        end
        @(posedge clk); #1;
        take = 1'b0;
    endtask

`ifdef HWPE_CTRL_SEQ_MULT_ACC_EN
    task automatic test_acc();
        int lat;
        logic rs;
        acc_in = 1'b0;
        do_op(8'd10, 8'd10, 1'b0, lat, rs);
        vectors++;
        if (prod !== 16'd100) begin miscompares++; $display("FAIL acc_first: got %0d expected 100", prod); end
        release_result();
        acc_in = 1'b1;
        do_op(8'd3, 8'd4, 1'b0, lat, rs);
        acc_in = 1'b0;
        vectors++;
        if (prod !== 16'd112) begin miscompares++; $display("FAIL acc_second: got %0d expected 112", prod); end
        release_result();
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_unsigned();
        test_signed();
        test_extremes();
        test_ignore_start_and_stall();
        test_clear_and_reset();
        test_back_to_back();
`ifdef HWPE_CTRL_SEQ_MULT_ACC_EN
        test_acc();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
